// File: rtl/serial_subtractor_pkg.sv
// sub_pkg: shared FSM encoding and counter sizing for the serial subtractor.
package sub_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t FIN  = 2'd2;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 1;
    localparam int NDIG = DEF_WIDTH / DEF_DIGIT;
    localparam int CW = $clog2(NDIG + 1);
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/serial_subtractor_digit.sv
// digit_subtractor: combinational ripple of DIGIT full-subtractor cells.
module digit_subtractor
    import sub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] diff,
    output logic             bo
);
    logic brw;
    always_comb begin
        diff = '0;
        brw = bi;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i] = x[i] ^ y[i] ^ brw;
            brw = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
        end
        bo = brw;
    end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle D = A - B - Bin, DIGIT bits per clock, LSB first,
// with start/busy/done handshake and borrow/overflow/zero flags.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int ND = WIDTH / DIGIT;
    localparam int CNTW = cnt_width(ND);
    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic [CNTW-1:0] cnt;
    logic brw, a_msb, b_msb, bo;
    logic [DIGIT-1:0] dig;
    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .x   (a_sh[DIGIT-1:0]),
        .y   (b_sh[DIGIT-1:0]),
        .bi  (brw),
        .diff(dig),
        .bo  (bo)
    );
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    d_sh  <= '0;
                    brw   <= bin;
                    cnt   <= '0;
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
                    state <= RUN;
                end
            end else if (state == RUN) begin
                // each digit enters at the top so the LSB digit ends up at bit 0
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                d_sh  <= (d_sh >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
                brw   <= bo;
                cnt   <= cnt + 1'b1;
                state <= (cnt == CNTW'(ND - 1)) ? FIN : RUN;
            end else if (state == FIN) begin
                d     <= d_sh;
                bout  <= brw;
                ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_sh[WIDTH-1]);
                zero  <= d_sh == '0;
                done  <= 1'b1;
                state <= IDLE;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
